// File: rtl/midi_pkg.sv
// Shared MIDI message types and helpers for the preset store and its serializer.
package midi_pkg;

  localparam logic [7:0] STATUS_MIN = 8'h80;
  localparam logic [7:0] STATUS_MAX = 8'hEF;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] len;
  } midi_msg_t;

  typedef enum logic [1:0] {
    IDLE,
    S_STATUS,
    S_D1,
    S_D2
  } ser_state_t;

  // Program change and channel pressure carry one data byte; the rest carry two.
  function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
    return (status[7:4] == 4'hC || status[7:4] == 4'hD) ? 2'd2 : 2'd3;
  endfunction

endpackage

// File: rtl/preset_store_if.sv
// Button, learn and transmit signals of the preset store, bundled for the top-level port list.
interface preset_store_if #(parameter int SLOTS = 4);

  logic [2:0]       btn_index;
  logic             save_mode;
  logic             learn_valid;
  logic [7:0]       learn_status;
  logic [7:0]       learn_data1;
  logic [7:0]       learn_data2;
  logic             tx_ready;
  logic             tx_valid;
  logic [7:0]       tx_byte;
  logic             busy;
  logic [SLOTS-1:0] slot_valid;
  logic             saved_pulse;

  modport slave (
    input  btn_index, save_mode, learn_valid, learn_status, learn_data1, learn_data2, tx_ready,
    output tx_valid, tx_byte, busy, slot_valid, saved_pulse
  );

  modport master (
    output btn_index, save_mode, learn_valid, learn_status, learn_data1, learn_data2, tx_ready,
    input  tx_valid, tx_byte, busy, slot_valid, saved_pulse
  );

endinterface

// File: rtl/midi_msg_serializer.sv
// Sends a snapshotted MIDI message one byte at a time over a valid/ready handshake.
module midi_msg_serializer
  import midi_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  midi_msg_t msg,
  input  logic      tx_ready,
  output logic      tx_valid,
  output logic [7:0] tx_byte,
  output logic      busy
);

  ser_state_t state, state_next;
  midi_msg_t  msg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The snapshot decouples an in-flight message from later re-saves of its slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q <= '0;
    end else if (load && state == IDLE) begin
      msg_q <= msg;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (load) state_next = S_STATUS;
      S_STATUS: if (tx_ready) state_next = S_D1;
      S_D1:     if (tx_ready) state_next = (msg_q.len == 2'd3) ? S_D2 : IDLE;
      S_D2:     if (tx_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    busy     = (state != IDLE);
    case (state)
      S_STATUS: begin
        tx_valid = 1'b1;
        tx_byte  = msg_q.status;
      end
      S_D1: begin
        tx_valid = 1'b1;
        tx_byte  = msg_q.d1;
      end
      S_D2: begin
        tx_valid = 1'b1;
        tx_byte  = msg_q.d2;
      end
      default: begin
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
      end
    endcase
  end

endmodule

// File: rtl/preset_store.sv
// Four-slot MIDI preset memory: learns channel messages, saves them to slots on a
// button press and replays a slot to the MIDI transmitter on recall.
module preset_store
  import midi_pkg::*;
#(
  parameter int SLOTS     = 4,
  parameter int MSG_BYTES = 3
)
(
  input  logic clk,
  input  logic rst,
  preset_store_if.slave bus
);

  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  midi_msg_t        hold_msg;
  logic             hold_valid;
  midi_msg_t        slots [SLOTS];
  logic [SLOTS-1:0] slot_valid_q;
  logic             saved_pulse_q;
  midi_msg_t        learned;
  logic [IDX_W-1:0] slot_idx;
  logic             learn_ok;
  logic             press;
  logic             save_hit;
  logic             recall_hit;
  logic             busy;
  logic             tx_valid;
  logic [7:0]       tx_byte;

  assign learn_ok = bus.learn_valid
                 && bus.learn_status >= STATUS_MIN
                 && bus.learn_status <= STATUS_MAX;

  // Presses arriving while a recall is still being sent are dropped, not queued.
  assign slot_idx   = IDX_W'(bus.btn_index - 3'd1);
  assign press      = !busy && bus.btn_index != 3'd0 && 32'(bus.btn_index) <= SLOTS;
  assign save_hit   = press && bus.save_mode && hold_valid;
  assign recall_hit = press && !bus.save_mode && slot_valid_q[slot_idx];

  always_comb begin
    learned        = '0;
    learned.status = bus.learn_status;
    learned.d1     = bus.learn_data1;
    learned.d2     = bus.learn_data2;
    learned.len    = midi_msg_len(bus.learn_status);
    if (learned.len > 2'(MSG_BYTES)) begin
      learned.len = 2'(MSG_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_msg   <= '0;
      hold_valid <= 1'b0;
    end else if (learn_ok) begin
      hold_msg   <= learned;
      hold_valid <= 1'b1;
    end
  end

  // A save in the same cycle as a learn stores the value held before the learn.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        slots[i] <= '0;
      end
      slot_valid_q  <= '0;
      saved_pulse_q <= 1'b0;
    end else begin
      saved_pulse_q <= save_hit;
      if (save_hit) begin
        slots[slot_idx]        <= hold_msg;
        slot_valid_q[slot_idx] <= 1'b1;
      end
    end
  end

  midi_msg_serializer u_serializer (
    .clk      (clk),
    .rst      (rst),
    .load     (recall_hit),
    .msg      (slots[slot_idx]),
    .tx_ready (bus.tx_ready),
    .tx_valid (tx_valid),
    .tx_byte  (tx_byte),
    .busy     (busy)
  );

  assign bus.tx_valid    = tx_valid;
  assign bus.tx_byte     = tx_byte;
  assign bus.busy        = busy;
  assign bus.slot_valid  = slot_valid_q;
  assign bus.saved_pulse = saved_pulse_q;

endmodule

// File: tb/tb_preset_store.sv
// Directed self-checking bench for preset_store: learn, save, recall, stalls, drops and reset.
module tb_preset_store;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checkCount = 0;
  int   failCount  = 0;

  preset_store_if #(.SLOTS(4)) bus ();

  preset_store #(.SLOTS(4), .MSG_BYTES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, clocks once, then samples 1 time unit after the edge.
  task automatic applyStimulus(input logic [2:0] btn, input logic save, input logic lv,
                               input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                               input logic rdy);
    bus.btn_index    = btn;
    bus.save_mode    = save;
    bus.learn_valid  = lv;
    bus.learn_status = st;
    bus.learn_data1  = d1;
    bus.learn_data2  = d2;
    bus.tx_ready     = rdy;
    @(posedge clk);
    #1;
    bus.btn_index   = 3'd0;
    bus.learn_valid = 1'b0;
  endtask

  task automatic idleCycle(input logic rdy);
    applyStimulus(3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, rdy);
  endtask

  task automatic learnMsg(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2);
    applyStimulus(3'd0, 1'b0, 1'b1, st, d1, d2, 1'b0);
  endtask

  // Recall with tx_ready held high: expects n bytes on consecutive cycles, then idle.
  task automatic recallAndCheck(input string tag, input logic [2:0] btn, input int n,
                                input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] exp_bytes [3];
    exp_bytes[0] = b0;
    exp_bytes[1] = b1;
    exp_bytes[2] = b2;
    applyStimulus(btn, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_valid%0d", tag, i), 32'(bus.tx_valid), 32'd1);
      checkOutput($sformatf("%s_busy%0d", tag, i), 32'(bus.busy), 32'd1);
      checkOutput($sformatf("%s_byte%0d", tag, i), 32'(bus.tx_byte), 32'(exp_bytes[i]));
      idleCycle(1'b1);
    end
    checkOutput($sformatf("%s_done_valid", tag), 32'(bus.tx_valid), 32'd0);
    checkOutput($sformatf("%s_done_busy", tag), 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [7:0] stall_bytes [6];
    logic       stall_valid [6];
    logic       stall_rdy   [6];

    bus.btn_index    = 3'd0;
    bus.save_mode    = 1'b0;
    bus.learn_valid  = 1'b0;
    bus.learn_status = 8'h00;
    bus.learn_data1  = 8'h00;
    bus.learn_data2  = 8'h00;
    bus.tx_ready     = 1'b0;
    rst              = 1'b1;
    idleCycle(1'b0);
    idleCycle(1'b0);
    rst = 1'b0;

    checkOutput("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    checkOutput("reset_tx_byte", 32'(bus.tx_byte), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_slot_valid", 32'(bus.slot_valid), 32'd0);
    checkOutput("reset_saved_pulse", 32'(bus.saved_pulse), 32'd0);

    // Save with an empty holding register does nothing.
    applyStimulus(3'd1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("empty_save_slots", 32'(bus.slot_valid), 32'd0);
    checkOutput("empty_save_pulse", 32'(bus.saved_pulse), 32'd0);

    // Learn a 3-byte control change, save to button 2, recall it.
    learnMsg(8'hB0, 8'h07, 8'h64);
    applyStimulus(3'd2, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("save2_slots", 32'(bus.slot_valid), 32'h2);
    checkOutput("save2_pulse_hi", 32'(bus.saved_pulse), 32'd1);
    checkOutput("save2_no_tx", 32'(bus.tx_valid), 32'd0);
    idleCycle(1'b0);
    checkOutput("save2_pulse_lo", 32'(bus.saved_pulse), 32'd0);
    recallAndCheck("recall2", 3'd2, 3, 8'hB0, 8'h07, 8'h64);

    // Program change is two bytes; d2 must never appear.
    learnMsg(8'hC3, 8'h05, 8'h99);
    applyStimulus(3'd4, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("save4_slots", 32'(bus.slot_valid), 32'hA);
    recallAndCheck("recall4", 3'd4, 2, 8'hC3, 8'h05, 8'h00);

    // Ignored inputs: empty slot recall, out-of-range button, non-channel status bytes.
    applyStimulus(3'd1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    checkOutput("recall_empty_valid", 32'(bus.tx_valid), 32'd0);
    checkOutput("recall_empty_busy", 32'(bus.busy), 32'd0);
    applyStimulus(3'd6, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    checkOutput("btn6_save_slots", 32'(bus.slot_valid), 32'hA);
    checkOutput("btn6_save_pulse", 32'(bus.saved_pulse), 32'd0);
    applyStimulus(3'd6, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    checkOutput("btn6_recall_valid", 32'(bus.tx_valid), 32'd0);
    learnMsg(8'h45, 8'h11, 8'h22);
    learnMsg(8'hF8, 8'h33, 8'h44);
    applyStimulus(3'd3, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("save3_slots", 32'(bus.slot_valid), 32'hE);
    recallAndCheck("recall3_hold_kept", 3'd3, 2, 8'hC3, 8'h05, 8'h00);

    // Stalled recall of slot 1 (button 2) with tx_ready 0,0,1,0,1,1.
    stall_rdy   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    stall_bytes = '{8'hB0, 8'hB0, 8'h07, 8'h07, 8'h64, 8'h00};
    stall_valid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    applyStimulus(3'd2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("stall_first_byte", 32'(bus.tx_byte), 32'hB0);
    for (int i = 0; i < 6; i++) begin
      idleCycle(stall_rdy[i]);
      checkOutput($sformatf("stall_valid%0d", i), 32'(bus.tx_valid), 32'(stall_valid[i]));
      checkOutput($sformatf("stall_byte%0d", i), 32'(bus.tx_byte), 32'(stall_bytes[i]));
    end

    // Presses during busy are dropped; a learn during a recall is still taken.
    applyStimulus(3'd4, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("busy_start_byte", 32'(bus.tx_byte), 32'hC3);
    applyStimulus(3'd1, 1'b1, 1'b1, 8'h90, 8'h3C, 8'h7F, 1'b0);
    checkOutput("busy_save_dropped", 32'(bus.slot_valid), 32'hE);
    checkOutput("busy_save_no_pulse", 32'(bus.saved_pulse), 32'd0);
    checkOutput("busy_byte_held", 32'(bus.tx_byte), 32'hC3);
    applyStimulus(3'd2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    checkOutput("busy_recall_dropped", 32'(bus.tx_byte), 32'h05);
    idleCycle(1'b1);
    checkOutput("busy_end_valid", 32'(bus.tx_valid), 32'd0);
    checkOutput("busy_end_busy", 32'(bus.busy), 32'd0);
    applyStimulus(3'd1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("save1_slots", 32'(bus.slot_valid), 32'hF);
    checkOutput("save1_pulse", 32'(bus.saved_pulse), 32'd1);
    recallAndCheck("recall1_learned_busy", 3'd1, 3, 8'h90, 8'h3C, 8'h7F);

    // Same-cycle learn and save stores the previously held message.
    applyStimulus(3'd4, 1'b1, 1'b1, 8'hE0, 8'h11, 8'h22, 1'b0);
    checkOutput("same_cycle_pulse", 32'(bus.saved_pulse), 32'd1);
    recallAndCheck("recall4_old_hold", 3'd4, 3, 8'h90, 8'h3C, 8'h7F);

    // Reset after the first byte is accepted aborts the transfer and clears the slots.
    applyStimulus(3'd2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    checkOutput("rst_pre_byte0", 32'(bus.tx_byte), 32'hB0);
    idleCycle(1'b1);
    checkOutput("rst_pre_byte1", 32'(bus.tx_byte), 32'h07);
    rst = 1'b1;
    idleCycle(1'b1);
    rst = 1'b0;
    checkOutput("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_slots", 32'(bus.slot_valid), 32'd0);
    applyStimulus(3'd2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    checkOutput("rst_recall_nothing", 32'(bus.tx_valid), 32'd0);
    applyStimulus(3'd1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("rst_hold_cleared", 32'(bus.slot_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/preset_store.md
# preset_store

Four-slot MIDI preset memory sitting directly downstream of the button decoder. Latches the most recent complete channel message from the MIDI input parser, stores it into the slot selected by a button press when save mode is active, and otherwise replays the stored message byte-by-byte to the MIDI transmitter over a valid/ready handshake. It also drives slot status to the LEDs.

## Interface
Parameters:
- `SLOTS`, 4: number of preset slots; fixed by the button count.
- `MSG_BYTES`, 3: maximum stored message length in bytes.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-high.
- `btn_index` in 3: one-cycle press code from the button decoder; 0 = none, 1..4 = slot 0..3; 5..7 ignored.
- `save_mode` in 1: qualifies `btn_index`; 1 = save, 0 = recall.
- `learn_valid` in 1: one-cycle strobe, complete message from the MIDI parser.
- `learn_status` in 8: status byte of the learned message.
- `learn_data1` in 8: first data byte.
- `learn_data2` in 8: second data byte; don't-care for 2-byte messages.
- `tx_ready` in 1: transmitter accepts `tx_byte` this cycle.
- `tx_valid` out 1: `tx_byte` is valid.
- `tx_byte` out 8: byte to transmit.
- `busy` out 1: a recall is in progress.
- `slot_valid` out 4: bit i set = slot i holds a message.
- `saved_pulse` out 1: one-cycle pulse on a successful save.

## Operation
- Holding register (status, d1, d2, len, valid) updates on `learn_valid` only if status is in 0x80..0xEF. Otherwise it keeps its old value.
- Length rule: status[7:4] is 0xC or 0xD -> 2 bytes; any other accepted status -> 3 bytes.
- A press is `btn_index` in 1..4 sampled while `busy`=0. Presses while `busy`=1 are dropped, not queued.
- Save press (`save_mode`=1):
  - If the holding register is valid: copy it into slot `btn_index-1`, set that `slot_valid` bit, and pulse `saved_pulse`.
  - If the holding register is empty: no effect.
  - A save never starts a transmission.
- Recall press (`save_mode`=0):
  - If the slot is valid: snapshot the slot into the serializer and send status, d1, then d2 (only when len=3).
  - If the slot is empty: no effect.
- Serializer FSM: IDLE -> S_STATUS -> S_D1 -> (len=3 ? S_D2 : IDLE); S_D2 -> IDLE.
  - Each send state holds `tx_valid`=1 with a stable `tx_byte` until `tx_valid && tx_ready`, then advances.
- Running status is never used; the status byte is always sent.
- `learn_valid` is accepted in every state. A recall in progress uses its snapshot and is unaffected.
- Slots persist until `rst`. A re-save overwrites the slot.

## Timing
- Reset values: `tx_valid`=0, `tx_byte`=0, `busy`=0, `slot_valid`=0, `saved_pulse`=0. Holding register invalid, FSM in IDLE.
- Save press at cycle N:
  - `slot_valid` bit and `saved_pulse` high at N+1.
  - `saved_pulse` low at N+2.
- Recall press at cycle N: `busy`=1 and `tx_valid`=1 with the status byte at N+1.
- Byte handshake: a byte accepted at cycle M puts the next byte on `tx_byte` at M+1, with `tx_valid` kept high, so throughput is 1 byte/cycle when `tx_ready` is held high.
- After the last byte is accepted at M: `tx_valid`=0 and `busy`=0 at M+1, and a new press is accepted at M+1.
- Same-cycle `learn_valid` and save press: the save stores the pre-update holding value. The new message is visible one cycle later.
- Same-cycle recall press and save to that slot cannot occur (single `btn_index`).
- `rst` mid-transmission: `tx_valid`=0 next cycle, the remaining bytes are discarded and the slots are cleared.
- `tx_ready` high while `tx_valid`=0: ignored.

## Structure
- Shared package `midi_pkg`:
  - `midi_msg_t` struct (status, d1, d2, len[1:0]).
  - Status range constants 0x80/0xEF.
  - `midi_msg_len()` function.
  - Serializer state enum `ser_state_t`.
- Sub-module `midi_msg_serializer`: takes a `midi_msg_t` with a load strobe and owns the FSM, `tx_valid`/`tx_byte`/`busy`.
- Top level holds the holding register, the slot array, and the press decode.

## Test plan
- Learn 0xB0,0x07,0x64; save to btn 2 -> `slot_valid`=0b0010 and `saved_pulse` for 1 cycle. Recall btn 2 with `tx_ready`=1 -> `tx_byte` 0xB0,0x07,0x64 on 3 consecutive cycles, then `busy`=0.
- Learn 0xC3,0x05; save/recall btn 4 -> exactly 2 bytes 0xC3,0x05, then `tx_valid`=0.
- Recall empty slot 1, save with empty holding register, `btn_index`=6, learn status 0x45 or 0xF8 -> no tx, `slot_valid` unchanged, holding register unchanged.
- `tx_ready` toggling 0,0,1,0,1,1 during a 3-byte recall -> `tx_byte` stable while stalled; exactly 3 transfers in order.
- A press during `busy` and a `learn_valid` during a recall -> press dropped, output bytes unchanged, and the new message saves correctly afterwards.
- `rst` asserted after the first accepted byte -> `tx_valid`=0 and `slot_valid`=0 next cycle; a later recall of that slot sends nothing.
